step_sequencer: RTL and testbench

Downstream consumer of the slow-clock divider output in the FPGA solver. It turns the divider's slow square wave, or a manual step button, into one-at-a-time step requests for the solver core over a req/ack handshake. It counts completed steps and halts when the solver reports a solution. It is the pacing stage between the switch-selected slow clock and the solver datapath.

---
 rtl/step_sequencer_pkg.sv | 13 +
 rtl/step_sequencer_edge_det.sv | 22 ++
 rtl/step_sequencer.sv | 115 +++++++++++
 tb/tb_step_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_sequencer_pkg.sv
// rtl/step_sequencer_pkg.sv - seq_pkg: sequencer state encoding and default counter width
package seq_pkg;

    // Sequencer states: waiting for a trigger, handshaking with the solver, halted on a solution
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int SEQ_CNT_W_DEF = 16;

endpackage

// File: rtl/step_sequencer_edge_det.sv
// rtl/step_sequencer_edge_det.sv - edge_det: single-register rising-edge detector
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic rise
);

    logic x_q;

    // Previous-cycle copy of x; resets low so an input already high out of reset reads as a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= 1'b0;
        end else begin
            x_q <= x;
        end
    end

    assign rise = x & ~x_q;

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - step_sequencer: trigger-to-step req/ack pacing; SEQ_OVERRUN_CNT_EN adds ovr_cnt
module step_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_in,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             clr,
    output logic             step_req,
    input  logic             step_ack,
    input  logic             solved,
    output logic             busy,
    output logic             done,
`ifdef SEQ_OVERRUN_CNT_EN
    output logic [CNT_W-1:0] ovr_cnt,
`endif
    output logic [CNT_W-1:0] step_cnt
);

    seq_state_t state;
    logic       rise_slow;
    logic       rise_btn;
    logic       trig;

    edge_det u_slow_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (slow_in),
        .rise  (rise_slow)
    );

    edge_det u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (step_btn),
        .rise  (rise_btn)
    );

    // Only the source selected by run_sw can trigger; the other is ignored entirely
    assign trig = run_sw ? rise_slow : rise_btn;

    // Step FSM with registered handshake/status outputs; clr overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_cnt <= '0;
        end else if (clr) begin
            state    <= IDLE;
            step_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state    <= WAIT;
                        step_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    // Triggers here (including the ack edge itself) are dropped, never queued
                    if (step_ack) begin
                        step_cnt <= step_cnt + CNT_W'(1);
                        step_req <= 1'b0;
                        busy     <= 1'b0;
                        if (solved) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    // Halted until clr or reset
                end
                default: begin
                    state    <= IDLE;
                    step_req <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_OVERRUN_CNT_EN
    logic drop;

    assign drop = trig && (state != IDLE);

    // Saturating count of triggers that arrived while a step was pending or after a solution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt <= '0;
        end else if (clr) begin
            ovr_cnt <= '0;
        end else if (drop && (ovr_cnt != {CNT_W{1'b1}})) begin
            ovr_cnt <= ovr_cnt + CNT_W'(1);
        end
    end
`else
    // Dropped triggers are silent in this build
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - tb_step_sequencer: directed and random checks against a behavioural model
module tb_step_sequencer;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        slow_in  = 1'b0;
    logic        run_sw   = 1'b0;
    logic        step_btn = 1'b0;
    logic        clr      = 1'b0;
    logic        step_ack = 1'b0;
    logic        solved   = 1'b0;

    logic        req16, busy16, done16;
    logic [15:0] cnt16;
    logic        req4, busy4, done4;
    logic [3:0]  cnt4;
`ifdef SEQ_OVERRUN_CNT_EN
    logic [15:0] ovr16;
    logic [3:0]  ovr4;
`endif

    step_sequencer #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .slow_in  (slow_in),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .clr      (clr),
        .step_req (req16),
        .step_ack (step_ack),
        .solved   (solved),
        .busy     (busy16),
        .done     (done16),
`ifdef SEQ_OVERRUN_CNT_EN
        .ovr_cnt  (ovr16),
`endif
        .step_cnt (cnt16)
    );

    step_sequencer #(.CNT_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .slow_in  (slow_in),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .clr      (clr),
        .step_req (req4),
        .step_ack (step_ack),
        .solved   (solved),
        .busy     (busy4),
        .done     (done4),
`ifdef SEQ_OVERRUN_CNT_EN
        .ovr_cnt  (ovr4),
`endif
        .step_cnt (cnt4)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_DONE = 2;

    int m_phase;
    int m_steps;
    int m_drops;
    bit m_slow_q;
    bit m_btn_q;

    int n_checks  = 0;
    int n_pass    = 0;
    int n_fail    = 0;
    int ack_delay = 0;
    int wait_ctr  = 0;
    bit ack_tie   = 1'b0;
    bit stray_ack = 1'b0;
    int obs_reqs  = 0;
    logic obs_req_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        m_phase  = M_IDLE;
        m_steps  = 0;
        m_drops  = 0;
        m_slow_q = 1'b0;
        m_btn_q  = 1'b0;
    endtask

    task automatic model_edge();
        bit r_slow, r_btn, trigger;
        if (!rst_n) begin
            model_reset();
            return;
        end
        r_slow   = slow_in && !m_slow_q;
        r_btn    = step_btn && !m_btn_q;
        m_slow_q = slow_in;
        m_btn_q  = step_btn;
        trigger  = run_sw ? r_slow : r_btn;
        if (clr) begin
            m_phase = M_IDLE;
            m_steps = 0;
            m_drops = 0;
        end else if (m_phase == M_IDLE) begin
            if (trigger) begin
                m_phase  = M_WAIT;
                wait_ctr = 0;
            end
        end else begin
            if (trigger) m_drops++;
            if (m_phase == M_WAIT && step_ack) begin
                m_steps++;
                m_phase = solved ? M_DONE : M_IDLE;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},   32'(req16),  32'(m_phase == M_WAIT));
        chk({tag, ".busy"},  32'(busy16), 32'(m_phase == M_WAIT));
        chk({tag, ".done"},  32'(done16), 32'(m_phase == M_DONE));
        chk({tag, ".cnt"},   32'(cnt16),  32'(m_steps % 65536));
        chk({tag, ".req4"},  32'(req4),   32'(m_phase == M_WAIT));
        chk({tag, ".done4"}, 32'(done4),  32'(m_phase == M_DONE));
        chk({tag, ".cnt4"},  32'(cnt4),   32'(m_steps % 16));
`ifdef SEQ_OVERRUN_CNT_EN
        chk({tag, ".ovr"},   32'(ovr16),  32'(sat(m_drops, 16)));
        chk({tag, ".ovr4"},  32'(ovr4),   32'(sat(m_drops, 4)));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
        if (req16 && !obs_req_q) obs_reqs++;
        obs_req_q = req16;
        if (m_phase == M_WAIT) begin
            step_ack = ack_tie || (wait_ctr >= ack_delay);
            wait_ctr++;
        end else begin
            step_ack = ack_tie || (stray_ack && ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic slow_pulse(input int hi, input int lo);
        slow_in = 1'b1;
        repeat (hi) tick();
        slow_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic btn_pulse(input int hi, input int lo);
        step_btn = 1'b1;
        repeat (hi) tick();
        step_btn = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_all("reset");
        chk("rst_req", 32'(req16), 32'd0);
        chk("rst_cnt", 32'(cnt16), 32'd0);
        #5 rst_n = 1'b1;
        repeat (2) tick();

        // Auto mode: 4 slow edges, solver acks after 3 cycles
        run_sw = 1'b1; ack_delay = 3; obs_reqs = 0;
        repeat (4) slow_pulse(6, 6);
        chk("auto_reqs", 32'(obs_reqs), 32'd4);
        chk("auto_cnt", 32'(cnt16), 32'd4);

        // Manual mode: slow_in toggles, two button pulses
        do_clr();
        run_sw = 1'b0; ack_delay = 2; obs_reqs = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) slow_in = ~slow_in;
            step_btn = (i == 5 || i == 6 || i == 25 || i == 26);
            tick();
        end
        slow_in = 1'b0; step_btn = 1'b0;
        tick();
        chk("man_reqs", 32'(obs_reqs), 32'd2);
        chk("man_cnt", 32'(cnt16), 32'd2);

        // Overrun: second button rise while waiting
        do_clr();
        ack_delay = 8; obs_reqs = 0;
        btn_pulse(1, 2);
        btn_pulse(1, 12);
        chk("ovr_reqs", 32'(obs_reqs), 32'd1);
        chk("ovr_cnt_steps", 32'(cnt16), 32'd1);
`ifdef SEQ_OVERRUN_CNT_EN
        chk("ovr_one", 32'(ovr16), 32'd1);
`endif

        // Solved on the third step, then triggers ignored
        do_clr();
        run_sw = 1'b1; ack_delay = 1; obs_reqs = 0; solved = 1'b0;
        slow_pulse(4, 4);
        slow_pulse(4, 4);
        solved = 1'b1;
        slow_pulse(4, 4);
        solved = 1'b0;
        chk("solved_done", 32'(done16), 32'd1);
        chk("solved_cnt", 32'(cnt16), 32'd3);
        repeat (3) slow_pulse(2, 2);
        chk("solved_noreq", 32'(obs_reqs), 32'd3);
        run_sw = 1'b0;
        repeat (20) btn_pulse(1, 1);
`ifdef SEQ_OVERRUN_CNT_EN
        chk("ovr_sat4", 32'(ovr4), 32'd15);
        chk("ovr_23", 32'(ovr16), 32'd23);
`endif
        do_clr();
        chk("clr_done", 32'(done16), 32'd0);
        chk("clr_cnt", 32'(cnt16), 32'd0);

        // clr in the middle of a handshake, then a normal restart
        run_sw = 1'b1; ack_delay = 100; obs_reqs = 0;
        slow_pulse(3, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrw_req", 32'(req16), 32'd0);
        chk("clrw_cnt", 32'(cnt16), 32'd0);
        ack_delay = 2;
        slow_pulse(4, 4);
        chk("clrw_reqs", 32'(obs_reqs), 32'd2);
        chk("clrw_cnt1", 32'(cnt16), 32'd1);

        // Zero-wait solver: step_ack tied high
        ack_tie = 1'b1; obs_reqs = 0;
        repeat (3) slow_pulse(2, 2);
        chk("zw_reqs", 32'(obs_reqs), 32'd3);
        chk("zw_cnt", 32'(cnt16), 32'd4);

        // Counter wrap on the 4-bit instance
        do_clr();
        for (int i = 0; i < 17; i++) begin
            slow_pulse(2, 2);
            if (i == 14) chk("wrap15", 32'(cnt4), 32'd15);
            if (i == 15) begin
                chk("wrap0", 32'(cnt4), 32'd0);
                chk("wrap16", 32'(cnt16), 32'd16);
            end
        end
        ack_tie = 1'b0;

        // Asynchronous reset between edges while waiting
        ack_delay = 50;
        slow_pulse(2, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(req16), 32'd0);
        chk("arst_busy", 32'(busy16), 32'd0);
        chk("arst_cnt", 32'(cnt16), 32'd0);
        chk("arst_cnt4", 32'(cnt4), 32'd0);
        chk("arst_done", 32'(done16), 32'd0);
        model_reset();
        obs_req_q = 1'b0;
        #2 rst_n = 1'b1;
        repeat (2) tick();

        // Randomized traffic against the model
        stray_ack = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) slow_in = ~slow_in;
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 49) == 0) run_sw = ~run_sw;
            clr       = ($urandom_range(0, 59) == 0);
            solved    = ($urandom_range(0, 9) == 0);
            ack_delay = $urandom_range(0, 4);
            tick();
        end
        clr = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
